kf_cfg_sequencer: RTL and testbench
===================================

// Module: kf_cfg_sequencer
// PURPOSE
// Burst configuration controller for the Kitten Fabric mesh. Accepts a command
// (tile, RAM select, base address, length) plus a word stream, and quiesces
// external spike injection. It waits for the target tile to go idle, then drives
// the mesh cfg_* write port one word per beat. Sits between host config FIFO and
// kf_mesh_2x2 cfg port; spike_gate feeds the ext_spike_in injection path.
// PARAMETERS
// NUM_TILES      4                   tiles addressable; cmd_tile >= NUM_TILES is an error
// TILE_W         2                   width of tile select
// ADDR_W         KF_SYNAPSE_ID_BITS  cfg address / burst length width (12)
// DATA_W         32                  config word width
// DRAIN_TIMEOUT  1023                max DRAIN cycles before abort
// SETTLE         2                   consecutive idle cycles required on tile_busy
// PORTS
// clk           in   1          clock
// rst_n         in   1          reset, asynchronous, active-high
// cmd_valid     in   1          command valid
// cmd_ready     out  1          command accepted when valid&ready
// cmd_tile      in   TILE_W     target tile
// cmd_sel       in   2          00 synapse RAM, 01 index RAM, 10 neuron param, 11 reserved
// cmd_base      in   ADDR_W     first cfg address
// cmd_len       in   ADDR_W     number of words minus 1
// wr_valid      in   1          data word valid
// wr_ready      out  1          data word accepted when valid&ready
// wr_data       in   DATA_W     config word
// tile_busy     in   NUM_TILES  per-tile busy from mesh
// spike_gate    out  1          1 = upstream must hold ext_spike_in_valid low
// cfg_we        out  1          write strobe to mesh
// cfg_tile_sel  out  TILE_W     target tile
// cfg_sel       out  2          RAM select
// cfg_addr      out  ADDR_W     write address
// cfg_wdata     out  DATA_W     write data
// seq_busy      out  1          state != IDLE
// done          out  1          one-cycle pulse at burst end, including error bursts
// err           out  1          one-cycle pulse with done on timeout or illegal command
// BEHAVIOUR
// - Reset (rst_n=1, async): state IDLE; all outputs 0; counters 0.
// - States: IDLE, DRAIN, WRITE, FLUSH, DONE. cmd_ready=1 only in IDLE;
//   wr_ready=1 only in WRITE and FLUSH.
// - IDLE: on cmd handshake, latch cmd fields and clear beat count. If cmd_sel==11
//   or cmd_tile>=NUM_TILES -> FLUSH with err pending. Otherwise -> DRAIN.
// - spike_gate is registered: 1 from the cycle after cmd accept through the DONE
//   cycle inclusive; 0 the cycle after DONE.
// - DRAIN: settle counter increments when tile_busy[tile]==0 and clears otherwise.
//   Reaching SETTLE -> WRITE. Timeout counter reaching DRAIN_TIMEOUT -> FLUSH with
//   err pending. Settle wins on the same cycle.
// - WRITE: each wr handshake registers cfg_we=1, addr=base+beat (mod 2^ADDR_W),
//   cfg_wdata=wr_data, tile/sel=latched values. Latency is 1 cycle from beat to
//   strobe. Bubbles in wr_valid produce cfg_we=0 cycles. tile_busy is ignored once
//   in WRITE.
// - Beat count==cmd_len on a handshake -> DONE. cmd_len=0 is one word; max burst
//   is 2^ADDR_W words.
// - FLUSH: consumes exactly cmd_len+1 words with cfg_we held 0, keeping the stream
//   aligned, then -> DONE.
// - DONE: done=1 for one cycle, plus err=1 if pending -> IDLE. The last cfg_we
//   coincides with DONE.
// - cfg_tile_sel, cfg_sel, cfg_addr and cfg_wdata hold their last values while
//   cfg_we=0.
// - Reset mid-burst: immediate return to IDLE; no done/err; remaining stream words
//   are the host's to flush.
// STRUCTURE
// - kf_pkg adds: kf_cfg_sel_e (KF_CFG_SYN=0, KF_CFG_IDX=1, KF_CFG_NPARAM=2,
//   KF_CFG_RSVD=3), kf_cfg_cmd_t {tile, sel, base, len}, kf_cfg_state_e.
// - Single module, no sub-modules; one FSM with beat, settle and timeout counters.
// TESTING
// - Command tile0/syn/base0/len31, 32 back-to-back words, tile_busy=0
//   -> 32 cfg_we at addr 0..31; done at last; spike_gate high for 35 cycles.
// - tile_busy[2]=1 for 50 cycles, command tile2/idx/len0
//   -> no cfg_we until busy low for 2 cycles; then one write; done, no err.
// - tile_busy[1] stuck 1, command len3 -> err+done at DRAIN_TIMEOUT;
//   4 words consumed; cfg_we never asserted.
// - cmd_sel=11 or tile=4 with len1 -> 2 words flushed; err+done; no cfg_we.
// - base=0xFFE, len3, wr_valid toggling every other cycle
//   -> addrs FFE, FFF, 000, 001; cfg_we gaps match bubbles.
// - rst_n asserted after beat 5 of 10 -> all outputs 0 asynchronously; new command
//   accepted after release.

Source files
------------

// File: rtl/kf_cfg_sequencer_pkg.sv
// Shared types for the Kitten Fabric burst configuration sequencer.
package kf_cfg_sequencer_pkg;

  localparam int KF_SYNAPSE_ID_BITS = 12;
  localparam int KF_TILE_W          = 2;

  typedef enum logic [1:0] {
    KF_CFG_SYN    = 2'd0,
    KF_CFG_IDX    = 2'd1,
    KF_CFG_NPARAM = 2'd2,
    KF_CFG_RSVD   = 2'd3
  } kf_cfg_sel_e;

  typedef enum logic [2:0] {
    KF_ST_IDLE  = 3'd0,
    KF_ST_DRAIN = 3'd1,
    KF_ST_WRITE = 3'd2,
    KF_ST_FLUSH = 3'd3,
    KF_ST_DONE  = 3'd4
  } kf_cfg_state_e;

  typedef struct packed {
    logic [KF_TILE_W-1:0]          tile;
    kf_cfg_sel_e                   sel;
    logic [KF_SYNAPSE_ID_BITS-1:0] base;
    logic [KF_SYNAPSE_ID_BITS-1:0] len;
  } kf_cfg_cmd_t;

  // A command is dropped (stream still consumed) for the reserved RAM or an absent tile.
  function automatic logic kf_cfg_illegal(input logic [1:0] sel, input int tile,
                                          input int num_tiles);
    return (sel == KF_CFG_RSVD) || (tile >= num_tiles);
  endfunction

endpackage

// File: rtl/kf_cfg_sequencer.sv
// Burst config writer: quiesces spike injection, waits for the target tile to
// settle idle, then streams words onto the mesh cfg port one per beat.
module kf_cfg_sequencer
  import kf_cfg_sequencer_pkg::*;
#(
  parameter int NUM_TILES     = 4,
  parameter int TILE_W        = KF_TILE_W,
  parameter int ADDR_W        = KF_SYNAPSE_ID_BITS,
  parameter int DATA_W        = 32,
  parameter int DRAIN_TIMEOUT = 1023,
  parameter int SETTLE        = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,        // active-high asynchronous reset
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [TILE_W-1:0]    cmd_tile,
  input  logic [1:0]           cmd_sel,
  input  logic [ADDR_W-1:0]    cmd_base,
  input  logic [ADDR_W-1:0]    cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [NUM_TILES-1:0] tile_busy,
  output logic                 spike_gate,
  output logic                 cfg_we,
  output logic [TILE_W-1:0]    cfg_tile_sel,
  output logic [1:0]           cfg_sel,
  output logic [ADDR_W-1:0]    cfg_addr,
  output logic [DATA_W-1:0]    cfg_wdata,
  output logic                 seq_busy,
  output logic                 done,
  output logic                 err
);

  localparam int ST_W = $clog2(SETTLE + 1);
  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = KF_ST_IDLE;
  localparam logic [2:0] S_DRAIN = KF_ST_DRAIN;
  localparam logic [2:0] S_WRITE = KF_ST_WRITE;
  localparam logic [2:0] S_FLUSH = KF_ST_FLUSH;
  localparam logic [2:0] S_DONE  = KF_ST_DONE;

  logic [2:0]        state_q, state_d;
  kf_cfg_cmd_t       cmd_q, cmd_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  logic [ST_W-1:0]   settle_q, settle_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic              errp_q, errp_d;
  logic              gate_q;
  logic              we_q, we_d;
  logic [TILE_W-1:0] tsel_q;
  logic [1:0]        sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              tile_idle;
  logic              illegal;

  assign tile_idle = ~tile_busy[cmd_q.tile];
  assign illegal   = kf_cfg_illegal(cmd_sel, int'(cmd_tile), NUM_TILES);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    beat_d   = beat_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    errp_d   = errp_q;
    we_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d    = '{tile: cmd_tile, sel: kf_cfg_sel_e'(cmd_sel), base: cmd_base, len: cmd_len};
          beat_d   = '0;
          settle_d = '0;
          tmo_d    = '0;
          errp_d   = illegal;
          state_d  = illegal ? S_FLUSH : S_DRAIN;
        end
      end
      S_DRAIN: begin
        settle_d = tile_idle ? settle_q + 1'b1 : '0;
        tmo_d    = tmo_q + 1'b1;
        // settle takes priority over a timeout landing on the same cycle
        if (tile_idle && settle_q == ST_W'(SETTLE - 1)) begin
          state_d = S_WRITE;
        end else if (tmo_q == TO_W'(DRAIN_TIMEOUT - 1)) begin
          state_d = S_FLUSH;
          errp_d  = 1'b1;
        end
      end
      S_WRITE, S_FLUSH: begin
        if (wr_valid) begin
          we_d   = (state_q == S_WRITE);
          beat_d = beat_q + 1'b1;
          if (beat_q == cmd_q.len) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        errp_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      beat_q   <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
      errp_q   <= 1'b0;
      gate_q   <= 1'b0;
      we_q     <= 1'b0;
      tsel_q   <= '0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      beat_q   <= beat_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      errp_q   <= errp_d;
      gate_q   <= (state_d != S_IDLE);
      we_q     <= we_d;
      if (we_d) begin
        tsel_q  <= cmd_q.tile;
        sel_q   <= cmd_q.sel;
        addr_q  <= cmd_q.base + beat_q;
        wdata_q <= wr_data;
      end
    end
  end

  // cmd_ready is masked by reset so every output reads 0 while reset is held
  assign cmd_ready    = (state_q == S_IDLE) & ~rst_n;
  assign wr_ready     = (state_q == S_WRITE) | (state_q == S_FLUSH);
  assign spike_gate   = gate_q;
  assign cfg_we       = we_q;
  assign cfg_tile_sel = tsel_q;
  assign cfg_sel      = sel_q;
  assign cfg_addr     = addr_q;
  assign cfg_wdata    = wdata_q;
  assign seq_busy     = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_DONE) & errp_q;

endmodule

// File: tb/tb_kf_cfg_sequencer.sv
// Scoreboard bench for kf_cfg_sequencer: driver pushes expected writes and burst
// endings, a negedge monitor pops and compares whatever the DUT presents.
module tb_kf_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_tile, cmd_sel;
  logic [11:0] cmd_base, cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  tile_busy;
  logic        spike_gate, cfg_we;
  logic [1:0]  cfg_tile_sel, cfg_sel;
  logic [11:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic        seq_busy, done, err;

  kf_cfg_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tile(cmd_tile), .cmd_sel(cmd_sel),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .tile_busy(tile_busy), .spike_gate(spike_gate),
    .cfg_we(cfg_we), .cfg_tile_sel(cfg_tile_sel), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .seq_busy(seq_busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  tile;
    logic [1:0]  sel;
    logic [11:0] addr;
    logic [31:0] data;
  } wexp_t;

  typedef struct {
    logic err;
    logic we;     // a final write lands in the done cycle
    int   gate;   // expected spike_gate cycles for the burst, -1 = not checked
  } eexp_t;

  wexp_t wq[$];
  eexp_t eq[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int gate_cnt = 0;
  int ends_seen = 0;
  int first_we_cyc = -1;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (spike_gate) gate_cnt++;
      if (cfg_we) begin
        n_chk++;
        if (first_we_cyc < 0) first_we_cyc = cyc_cnt;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_we got addr=%h data=%h, required no write", cfg_addr, cfg_wdata);
        end else begin
          wexp_t w;
          w = wq.pop_front();
          if ({cfg_tile_sel, cfg_sel, cfg_addr, cfg_wdata} !== {w.tile, w.sel, w.addr, w.data}) begin
            n_err++;
            $display("FAIL cfg_write got t=%0d s=%0d a=%h d=%h, required t=%0d s=%0d a=%h d=%h",
                     cfg_tile_sel, cfg_sel, cfg_addr, cfg_wdata, w.tile, w.sel, w.addr, w.data);
          end
        end
      end
      if (err && !done) begin
        n_chk++;
        n_err++;
        $display("FAIL err_without_done got err=1, required err only with done");
      end
      if (done) begin
        n_chk++;
        if (eq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done got done=1, required no burst end");
        end else begin
          eexp_t e;
          e = eq.pop_front();
          if (err !== e.err || cfg_we !== e.we || wq.size() != 0 ||
              (e.gate >= 0 && gate_cnt != e.gate)) begin
            n_err++;
            $display("FAIL burst_end got err=%b we=%b left=%0d gate=%0d, required err=%b we=%b left=0 gate=%0d",
                     err, cfg_we, wq.size(), gate_cnt, e.err, e.we, e.gate);
          end
        end
        gate_cnt = 0;
        ends_seen++;
      end
    end
  end

  // bubble: 0 = continuous, 1 = valid every other cycle, 2 = random
  task automatic run_cmd(input logic [1:0] tile, input logic [1:0] sel, input logic [11:0] base,
                         input logic [11:0] len, input int bubble, input bit expect_to,
                         input int gate, input int abort_at);
    logic [31:0] words[$];
    bit legal, ok;
    int idx, cyc, target;
    eexp_t e;
    legal  = (sel != 2'd3) && (int'(tile) < 4);
    target = ends_seen + 1;
    for (int i = 0; i <= int'(len); i++) begin
      wexp_t w;
      words.push_back($urandom);
      w.tile = tile;
      w.sel  = sel;
      w.addr = base + 12'(i);
      w.data = words[i];
      if (legal && !expect_to) wq.push_back(w);
    end
    e.err  = !legal || expect_to;
    e.we   = legal && !expect_to;
    e.gate = gate;
    eq.push_back(e);

    cmd_valid = 1'b1; cmd_tile = tile; cmd_sel = sel; cmd_base = base; cmd_len = len;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL cmd_accept got cmd_ready=0 for 100 cycles, required acceptance");
    end

    idx = 0; cyc = 0;
    while (idx <= int'(len) && cyc < 5000 && !(abort_at >= 0 && idx == abort_at)) begin
      wr_valid = (bubble == 0) ? 1'b1 : (bubble == 1) ? ((cyc % 2) == 0) : 1'($urandom);
      wr_data  = words[idx];
      @(negedge clk);
      if (wr_valid && wr_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    wr_valid = 1'b0;

    if (abort_at < 0) begin
      n_chk++;
      if (idx != int'(len) + 1) begin
        n_err++;
        $display("FAIL words_consumed got %0d, required %0d", idx, int'(len) + 1);
      end
      cyc = 0;
      while (ends_seen < target && cyc < 3000) begin
        @(posedge clk); #1;
        cyc++;
      end
      n_chk++;
      if (ends_seen < target) begin
        n_err++;
        $display("FAIL done_wait got no done in 3000 cycles, required done");
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    n_chk++;
    if ({cmd_ready, wr_ready, spike_gate, cfg_we, cfg_tile_sel, cfg_sel, cfg_addr, cfg_wdata,
         seq_busy, done, err} !== '0) begin
      n_err++;
      $display("FAIL %s got rdy=%b wrdy=%b gate=%b we=%b busy=%b done=%b err=%b addr=%h, required all 0",
               name, cmd_ready, wr_ready, spike_gate, cfg_we, seq_busy, done, err, cfg_addr);
    end
  endtask

  initial begin
    int rel_cyc;
    rst_n = 1'b1;
    cmd_valid = 1'b0; cmd_tile = '0; cmd_sel = '0; cmd_base = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; tile_busy = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1 || seq_busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset got ready=%b busy=%b, required ready=1 busy=0", cmd_ready, seq_busy);
    end
    @(posedge clk); #1;

    // 32-word burst, tile idle: gate spans 2 settle + 32 beats + done
    run_cmd(2'd0, 2'd0, 12'h000, 12'd31, 0, 1'b0, 35, -1);

    // tile 2 busy for 50 cycles: first write three edges after release
    tile_busy = 4'b0100;
    first_we_cyc = -1;
    rel_cyc = 0;
    fork
      run_cmd(2'd2, 2'd1, 12'h123, 12'd0, 0, 1'b0, -1, -1);
      begin
        repeat (50) @(posedge clk);
        #1;
        tile_busy[2] = 1'b0;
        rel_cyc = cyc_cnt;
      end
    join
    n_chk++;
    if (first_we_cyc - rel_cyc != 3) begin
      n_err++;
      $display("FAIL settle_delay got %0d cycles, required 3", first_we_cyc - rel_cyc);
    end

    // stuck busy: timeout after 1023 drain cycles, 4 words flushed
    tile_busy = 4'b0010;
    run_cmd(2'd1, 2'd0, 12'h040, 12'd3, 0, 1'b1, 1023 + 4 + 1, -1);
    tile_busy = '0;

    // reserved select: two words flushed with err
    run_cmd(2'd2, 2'd3, 12'h010, 12'd1, 0, 1'b0, 3, -1);
    run_cmd(2'd3, 2'd3, 12'h7F0, 12'd1, 1, 1'b0, -1, -1);

    // address wrap with bubbles
    run_cmd(2'd0, 2'd1, 12'hFFE, 12'd3, 1, 1'b0, -1, -1);

    // reset after beat 5 of 10
    run_cmd(2'd3, 2'd2, 12'h200, 12'd9, 0, 1'b0, -1, 5);
    rst_n = 1'b1;
    #1;
    check_all_zero("midburst_reset");
    wq.delete();
    eq.delete();
    @(posedge clk); #1;
    rst_n = 1'b0;
    gate_cnt = 0;
    @(posedge clk); #1;
    run_cmd(2'd1, 2'd2, 12'h300, 12'd2, 0, 1'b0, -1, -1);

    for (int r = 0; r < 10; r++) begin
      logic [1:0] t;
      t = 2'($urandom_range(0, 3));
      tile_busy = 4'($urandom) & ~(4'b0001 << t);
      run_cmd(t, 2'($urandom_range(0, 3)), 12'($urandom), 12'($urandom_range(0, 12)),
              int'($urandom_range(0, 2)), 1'b0, -1, -1);
    end
    tile_busy = '0;

    repeat (3) @(posedge clk);
    n_chk++;
    if (wq.size() != 0 || eq.size() != 0) begin
      n_err++;
      $display("FAIL leftover got writes=%0d ends=%0d, required 0 and 0", wq.size(), eq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
